// File: rtl/boron_pkg.sv
// Shared BORON definitions: block/key widths, controller FSM encoding, key schedule constants.
// Define BORON_KEY128_EN to build for a 128-bit master key; otherwise the key is 80 bits.
package boron_pkg;

  localparam int BLK_W    = 64;
  localparam int KEY80_W  = 80;
  localparam int KEY128_W = 128;

`ifdef BORON_KEY128_EN
  localparam bit KEY128_EN = 1'b1;
`else
  localparam bit KEY128_EN = 1'b0;
`endif

  localparam int KEY_W   = KEY128_EN ? KEY128_W : KEY80_W;
  localparam int KEY_ROT = 13;
  localparam int RC_HI   = 63;
  localparam int RC_LO   = 59;
  localparam int RC_W    = RC_HI - RC_LO + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } boron_state_e;

  // Whole-register rotate left by KEY_ROT
  function automatic logic [KEY_W-1:0] key_rotl(input logic [KEY_W-1:0] k);
    return {k[KEY_W-KEY_ROT-1:0], k[KEY_W-1:KEY_W-KEY_ROT]};
  endfunction

endpackage

// File: rtl/boron_perm_layer.sv
// BORON linear layer on four 16-bit words: byte swap within each word (block shuffle),
// rotate word i left by 1/4/7/9, then each odd word absorbs its even neighbour by XOR.
module boron_perm_layer
  import boron_pkg::*;
(
  input  logic [BLK_W-1:0] din,
  output logic [BLK_W-1:0] dout
);

  function automatic logic [15:0] rotl16(input logic [15:0] v, input int unsigned amt);
    return (v << amt) | (v >> (16 - amt));
  endfunction

  logic [15:0] r0, r1, r2, r3;

  always_comb begin
    r0   = rotl16({din[7:0],   din[15:8]},  1);
    r1   = rotl16({din[23:16], din[31:24]}, 4);
    r2   = rotl16({din[39:32], din[47:40]}, 7);
    r3   = rotl16({din[55:48], din[63:56]}, 9);
    dout = {r3 ^ r2, r2, r1 ^ r0, r0};
  end

endmodule

// File: rtl/s_box.sv
// BORON 4-bit S-box, purely combinational.
module s_box (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = 4'h0;
    case (din)
      4'h0: dout = 4'hE;
      4'h1: dout = 4'h4;
      4'h2: dout = 4'hB;
      4'h3: dout = 4'h1;
      4'h4: dout = 4'h7;
      4'h5: dout = 4'h9;
      4'h6: dout = 4'hC;
      4'h7: dout = 4'hA;
      4'h8: dout = 4'hD;
      4'h9: dout = 4'h2;
      4'hA: dout = 4'h0;
      4'hB: dout = 4'hF;
      4'hC: dout = 4'h8;
      4'hD: dout = 4'h5;
      4'hE: dout = 4'h3;
      4'hF: dout = 4'h6;
      default: dout = 4'h0;
    endcase
  end

endmodule

// File: rtl/s_box_layer_enc.sv
// Encryption S-box layer: sixteen parallel 4-bit S-boxes across the 64-bit block.
module s_box_layer_enc
  import boron_pkg::*;
(
  input  logic [BLK_W-1:0] din,
  output logic [BLK_W-1:0] dout
);

  for (genvar i = 0; i < BLK_W / 4; i++) begin : g_nib
    s_box u_s_box (
      .din  (din[4*i +: 4]),
      .dout (dout[4*i +: 4])
    );
  end

endmodule

// File: rtl/boron_enc_ctrl.sv
// Iterative BORON encryption controller: one round per cycle, final key whitening,
// valid/ready output. Define BORON_KEY128_EN for a 128-bit master key schedule.
module boron_enc_ctrl
  import boron_pkg::*;
#(
  parameter int ROUNDS = 25,
  parameter int RCNT_W = 5
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic [BLK_W-1:0]  plainIn,
  input  logic [KEY_W-1:0]  keyIn,
  input  logic              inValid,
  output logic              inReady,
  output logic [BLK_W-1:0]  cipherOut,
  output logic              outValid,
  input  logic              outReady,
  output logic              busy,
  output logic [RCNT_W-1:0] roundCnt,
  output boron_state_e      state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // inReady is high only in IDLE; outValid stays high with cipherOut stable until outReady.

  boron_state_e      state_q, state_d;
  logic [BLK_W-1:0]  blk_q, blk_d;
  logic [BLK_W-1:0]  cipher_q, cipher_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [RCNT_W-1:0] rnd_q, rnd_d;

  logic [BLK_W-1:0]  sbox_out, perm_out;
  logic [KEY_W-1:0]  key_rot, key_next;
  logic [3:0]        key_nib0_s;
  logic [RC_W-1:0]   rc;
  logic              last_round;

  s_box_layer_enc u_sbox_layer (
    .din  (blk_q ^ key_q[BLK_W-1:0]),
    .dout (sbox_out)
  );

  boron_perm_layer u_perm (
    .din  (sbox_out),
    .dout (perm_out)
  );

  assign key_rot    = key_rotl(key_q);
  assign rc         = RC_W'(rnd_q) + RC_W'(1);
  assign last_round = (rnd_q == RCNT_W'(ROUNDS - 1));

  s_box u_key_sbox0 (
    .din  (key_rot[3:0]),
    .dout (key_nib0_s)
  );

`ifdef BORON_KEY128_EN
  logic [3:0] key_nib1_s;

  s_box u_key_sbox1 (
    .din  (key_rot[7:4]),
    .dout (key_nib1_s)
  );
`endif

  always_comb begin
    key_next      = key_rot;
    key_next[3:0] = key_nib0_s;
`ifdef BORON_KEY128_EN
    key_next[7:4] = key_nib1_s;
`endif
    key_next[RC_HI:RC_LO] = key_rot[RC_HI:RC_LO] ^ rc;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q  <= ST_IDLE;
      blk_q    <= '0;
      cipher_q <= '0;
      key_q    <= '0;
      rnd_q    <= '0;
    end else begin
      state_q  <= state_d;
      blk_q    <= blk_d;
      cipher_q <= cipher_d;
      key_q    <= key_d;
      rnd_q    <= rnd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (inValid)    state_d = ST_ROUND;
      ST_ROUND: if (last_round) state_d = ST_FINAL;
      ST_FINAL:                 state_d = ST_DONE;
      ST_DONE:  if (outReady)   state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // The round counter saturates at ROUNDS-1 so SW can read it through FINAL/DONE
  always_comb begin
    blk_d    = blk_q;
    key_d    = key_q;
    rnd_d    = rnd_q;
    cipher_d = cipher_q;
    case (state_q)
      ST_IDLE: begin
        if (inValid) begin
          blk_d = plainIn;
          key_d = keyIn;
          rnd_d = '0;
        end
      end
      ST_ROUND: begin
        blk_d = perm_out;
        key_d = key_next;
        if (!last_round) rnd_d = rnd_q + RCNT_W'(1);
      end
      ST_FINAL: cipher_d = blk_q ^ key_q[BLK_W-1:0];
      default: ;
    endcase
  end

  always_comb begin
    inReady   = (state_q == ST_IDLE);
    outValid  = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
    cipherOut = cipher_q;
    roundCnt  = rnd_q;
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_boron_enc_ctrl.sv
// Bench for boron_enc_ctrl: KAT-style table, backpressure, mid-op reset and a
// back-to-back random stream, all checked against a word/nibble-level reference model.
module tb_boron_enc_ctrl;
  import boron_pkg::*;

  localparam int ROUNDS  = 25;
  localparam int RCNT_W  = 5;
  localparam int LAT     = ROUNDS + 2;
  localparam int NSTREAM = 100;

  logic              clk = 1'b0;
  logic              rstN;
  logic [BLK_W-1:0]  plainIn;
  logic [KEY_W-1:0]  keyIn;
  logic              inValid;
  logic              inReady;
  logic [BLK_W-1:0]  cipherOut;
  logic              outValid;
  logic              outReady;
  logic              busy;
  logic [RCNT_W-1:0] roundCnt;
  boron_state_e      state_dbg;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  logic [3:0] sbox_tab [16] = '{4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
                                4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6};
  int rot_tab [4] = '{1, 4, 7, 9};

  typedef struct {
    logic [63:0]  plain;
    logic [127:0] key;
    int           hold;
    logic [63:0]  exp;
  } vec_t;

  boron_enc_ctrl #(.ROUNDS(ROUNDS), .RCNT_W(RCNT_W)) dut (
    .clk       (clk),
    .rstN      (rstN),
    .plainIn   (plainIn),
    .keyIn     (keyIn),
    .inValid   (inValid),
    .inReady   (inReady),
    .cipherOut (cipherOut),
    .outValid  (outValid),
    .outReady  (outReady),
    .busy      (busy),
    .roundCnt  (roundCnt),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] key_mask();
    logic [127:0] m;
    m = '1;
    return m >> (128 - KEY_W);
  endfunction

  // One cipher round on an already key-mixed block
  function automatic logic [63:0] ref_round(input logic [63:0] x);
    logic [63:0] s;
    logic [15:0] w [4];
    for (int i = 0; i < 16; i++) s[4*i +: 4] = sbox_tab[x[4*i +: 4]];
    for (int i = 0; i < 4; i++) begin
      w[i] = {s[16*i +: 8], s[16*i+8 +: 8]};
      w[i] = (w[i] << rot_tab[i]) | (w[i] >> (16 - rot_tab[i]));
    end
    w[1] = w[1] ^ w[0];
    w[3] = w[3] ^ w[2];
    return {w[3], w[2], w[1], w[0]};
  endfunction

  function automatic logic [127:0] ref_sched(input logic [127:0] k, input int r);
    logic [127:0] kk;
    kk = ((k << KEY_ROT) | (k >> (KEY_W - KEY_ROT))) & key_mask();
    kk[3:0] = sbox_tab[kk[3:0]];
    if (KEY_W == 128) kk[7:4] = sbox_tab[kk[7:4]];
    kk[63:59] = kk[63:59] ^ 5'(r);
    return kk;
  endfunction

  function automatic logic [63:0] ref_encrypt(input logic [63:0] p, input logic [127:0] k);
    logic [63:0]  x;
    logic [127:0] kk;
    x  = p;
    kk = k & key_mask();
    for (int r = 1; r <= ROUNDS; r++) begin
      x  = ref_round(x ^ kk[63:0]);
      kk = ref_sched(kk, r);
    end
    return x ^ kk[63:0];
  endfunction

  // Single transaction from IDLE, with hold cycles of output backpressure
  task automatic do_txn(input logic [63:0] p, input logic [127:0] k, input int hold,
                        input logic [63:0] exp);
    int          cyc;
    logic        bad_busy;
    logic        fin_ok;
    logic [127:0] junk;
    check("idle_in_ready", 64'(inReady), 64'd1);
    plainIn = p;
    keyIn   = k[KEY_W-1:0];
    inValid = 1'b1;
    step();
    inValid  = 1'b0;
    plainIn  = rand64();
    junk     = rand128();
    keyIn    = junk[KEY_W-1:0];
    cyc      = 1;
    bad_busy = 1'b0;
    fin_ok   = 1'b0;
    while (!outValid && cyc < LAT + 20) begin
      if (!busy || inReady) bad_busy = 1'b1;
      if (cyc == LAT - 1)
        fin_ok = (state_dbg == ST_FINAL) && (roundCnt == RCNT_W'(ROUNDS - 1));
      step();
      cyc++;
    end
    check("latency", 64'(cyc), 64'(LAT));
    check("busy_during_run", 64'(bad_busy), 64'd0);
    check("final_state_round_cnt", 64'(fin_ok), 64'd1);
    check("cipher", cipherOut, exp);
    check("done_round_cnt", 64'(roundCnt), 64'(ROUNDS - 1));
    for (int i = 0; i < hold; i++) begin
      outReady = 1'b0;
      inValid  = 1'($urandom_range(0, 1));
      step();
      check("hold_stable", {63'd0, outValid & ~inReady & busy}, 64'd1);
      check("hold_cipher", cipherOut, exp);
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    step();
    outReady = 1'b0;
    check("post_handshake_idle", {61'd0, inReady, outValid, busy}, 64'b100);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         tab [6];
    int           cyc;
    int           last_out;
    int           n_out;
    int           pushed;
    logic [63:0]  p;
    logic [127:0] k;

    rstN = 1'b0; inValid = 1'b0; outReady = 1'b0; plainIn = '0; keyIn = '0;
    #1;
    check("rst_in_ready", 64'(inReady), 64'd1);
    check("rst_out_valid", 64'(outValid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_round_cnt", 64'(roundCnt), 64'd0);
    check("rst_cipher", cipherOut, 64'd0);
    step();
    step();
    rstN = 1'b1;
    step();

    tab[0] = '{64'h0, 128'h0, 0, 64'h0};
    tab[1] = '{'1, '1, 10, 64'h0};
    for (int i = 2; i < 6; i++) tab[i] = '{rand64(), rand128(), $urandom_range(0, 3), 64'h0};
    for (int i = 0; i < 6; i++) tab[i].exp = ref_encrypt(tab[i].plain, tab[i].key);
    for (int i = 0; i < 6; i++) do_txn(tab[i].plain, tab[i].key, tab[i].hold, tab[i].exp);

    // Abort in the middle of the rounds
    plainIn = rand64();
    k       = rand128();
    keyIn   = k[KEY_W-1:0];
    inValid = 1'b1;
    step();
    inValid = 1'b0;
    cyc = 0;
    while (roundCnt != RCNT_W'(12) && cyc < 40) begin
      step();
      cyc++;
    end
    check("midop_round12", 64'(roundCnt), 64'd12);
    rstN = 1'b0;
    #1;
    check("midop_rst_in_ready", 64'(inReady), 64'd1);
    check("midop_rst_out_valid", 64'(outValid), 64'd0);
    check("midop_rst_busy", 64'(busy), 64'd0);
    check("midop_rst_round_cnt", 64'(roundCnt), 64'd0);
    check("midop_rst_cipher", cipherOut, 64'd0);
    step();
    step();
    check("midop_no_output", 64'(outValid), 64'd0);
    rstN = 1'b1;
    step();
    p = rand64();
    k = rand128();
    do_txn(p, k, 1, ref_encrypt(p, k));

    // Back-to-back stream: inValid held high, consumer always ready
    inValid  = 1'b1;
    outReady = 1'b1;
    n_out    = 0;
    pushed   = 0;
    last_out = -1;
    cyc      = 0;
    while (n_out < NSTREAM && cyc < NSTREAM * (LAT + 1) + 100) begin
      if (inReady) begin
        if (pushed < NSTREAM) begin
          p       = rand64();
          k       = rand128();
          plainIn = p;
          keyIn   = k[KEY_W-1:0];
          exp_q.push_back(ref_encrypt(p, k));
          pushed++;
        end else begin
          inValid = 1'b0;
        end
      end
      if (outValid) begin
        if (exp_q.size() == 0) begin
          check("stream_unexpected_output", 64'd1, 64'd0);
        end else begin
          check("stream_cipher", cipherOut, exp_q.pop_front());
        end
        if (last_out >= 0) check("stream_period", 64'(cyc - last_out), 64'(LAT + 1));
        last_out = cyc;
        n_out++;
      end
      step();
      cyc++;
    end
    check("stream_outputs", 64'(n_out), 64'(NSTREAM));
    inValid  = 1'b0;
    outReady = 1'b0;
    step();
    check("stream_end_idle", 64'(inReady), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
